// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O controller sitting between the load/store path and data memory.
// Decodes addresses into output ports, synchronised input ports, edge status/mask, or memory.
module io_port_ctrl #(
    parameter int                     ADDR_W      = 8,
    parameter int                     OUT_PORTS   = 8,
    parameter int                     IN_PORTS    = 2,
    parameter int                     IN_BASE     = 8,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [OUT_PORTS-1:0]   OUT_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [31:0]           wr_data,
    input  logic [IN_PORTS-1:0]   in_pins,
    output logic [OUT_PORTS-1:0]  out_pins,
    output logic                  mem_we,
    output logic                  sel_port_read,
    output logic [31:0]           rd_data,
    output logic                  irq
);

    localparam logic [31:0] STAT_ADDR = 32'(IN_BASE + IN_PORTS);
    localparam logic [31:0] MASK_ADDR = 32'(IN_BASE + IN_PORTS + 1);

    logic [31:0] addr_ext;
    assign addr_ext = 32'(addr);

    logic [OUT_PORTS-1:0]                  out_q, out_d, out_sel;
    logic [SYNC_STAGES-1:0][IN_PORTS-1:0]  sync_q;
    logic [IN_PORTS-1:0]                   sync_last, prev_q, edge_det;
    logic [IN_PORTS-1:0]                   flags_q, flags_d, mask_q, mask_d;
    logic [IN_PORTS-1:0]                   in_sel, clr;
    logic                                  is_out, is_in, is_stat, is_mask, is_port;

    // One-hot per-bit decode doubles as the read mux select and the store enable.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_PORTS; gi++) begin : g_out
            assign out_sel[gi] = (addr_ext == 32'(gi));
            assign out_d[gi]   = (wr_en && out_sel[gi]) ? wr_data[0] : out_q[gi];
        end
        for (gi = 0; gi < IN_PORTS; gi++) begin : g_in
            assign in_sel[gi] = (addr_ext == 32'(IN_BASE + gi));
        end
    endgenerate

    assign is_out  = |out_sel;
    assign is_in   = |in_sel;
    assign is_stat = (addr_ext == STAT_ADDR);
    assign is_mask = (addr_ext == MASK_ADDR);
    assign is_port = is_out | is_in | is_stat | is_mask;

    assign mem_we        = wr_en & ~is_port;
    assign sel_port_read = rd_en & is_port;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign edge_det  = sync_last ^ prev_q;

    // Write-1-to-clear; a coincident edge re-sets the flag so no event is lost.
    assign clr     = (wr_en && is_stat) ? wr_data[IN_PORTS-1:0] : '0;
    assign flags_d = (flags_q & ~clr) | edge_det;
    assign mask_d  = (wr_en && is_mask) ? wr_data[IN_PORTS-1:0] : mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= OUT_RESET;
            sync_q  <= '0;
            prev_q  <= '0;
            flags_q <= '0;
            mask_q  <= '0;
        end else begin
            out_q   <= out_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_pins};
            prev_q  <= sync_last;
            flags_q <= flags_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel_port_read) begin
            if (is_out)
                rd_data[0] = |(out_sel & out_q);
            else if (is_in)
                rd_data[0] = |(in_sel & sync_last);
            else if (is_stat)
                rd_data[IN_PORTS-1:0] = flags_q;
            else
                rd_data[IN_PORTS-1:0] = mask_q;
        end
    end

    assign out_pins = out_q;
    assign irq      = |(flags_q & mask_q);

    // Only the low bits of the store word carry port data.
    logic unused_wr_bits;
    assign unused_wr_bits = &{1'b0, wr_data[31:IN_PORTS]};

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl: expectations are queued at stimulus time and drained per scenario.
module tb_io_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic        wr_en, rd_en;
    logic [31:0] wr_data;
    logic [1:0]  in_pins;
    logic [7:0]  out_pins;
    logic        mem_we, sel_port_read, irq;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    io_port_ctrl #(
        .ADDR_W(8), .OUT_PORTS(8), .IN_PORTS(2), .IN_BASE(8),
        .SYNC_STAGES(2), .OUT_RESET(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .in_pins(in_pins), .out_pins(out_pins),
        .mem_we(mem_we), .sel_port_read(sel_port_read), .rd_data(rd_data), .irq(irq)
    );

    typedef struct { string name; logic [31:0] val; } exp_t;
    exp_t        sb[$];
    logic [31:0] obs[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e; logic [31:0] o;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0; in_pins = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        sb.push_back('{name:"rst_out_pins", val:32'hA5}); obs.push_back(32'(out_pins));
        sb.push_back('{name:"rst_irq", val:32'h0});       obs.push_back(32'(irq));
        sb.push_back('{name:"rst_mem_we", val:32'h0});    obs.push_back(32'(mem_we));
        rd_en = 1'b1; addr = 8'd10; #1;
        sb.push_back('{name:"rst_stat_rd", val:32'h0});   obs.push_back(rd_data);
        sb.push_back('{name:"rst_stat_sel", val:32'h1});  obs.push_back(32'(sel_port_read));
        addr = 8'd11; #1;
        sb.push_back('{name:"rst_mask_rd", val:32'h0});   obs.push_back(rd_data);
        rd_en = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
            else $display("pass %s: %h", e.name, o);
        end
    endtask

    task automatic test_out_store();
        exp_t e; logic [31:0] o;
        tick();
        wr_en = 1'b1; addr = 8'd3; wr_data = 32'h1; #1;
        sb.push_back('{name:"out3_mem_we", val:32'h0}); obs.push_back(32'(mem_we));
        tick();
        addr = 8'd7; wr_data = 32'h0; #1;
        sb.push_back('{name:"out7_mem_we", val:32'h0}); obs.push_back(32'(mem_we));
        tick();
        wr_en = 1'b0; #1;
        sb.push_back('{name:"out_pins_2d", val:32'h2D}); obs.push_back(32'(out_pins));
        rd_en = 1'b1; addr = 8'd3; #1;
        sb.push_back('{name:"out3_rd", val:32'h1});     obs.push_back(rd_data);
        addr = 8'd7; #1;
        sb.push_back('{name:"out7_rd", val:32'h0});     obs.push_back(rd_data);
        rd_en = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
            else $display("pass %s: %h", e.name, o);
        end
    endtask

    task automatic test_mem();
        exp_t e; logic [31:0] o;
        wr_en = 1'b1; addr = 8'd12; wr_data = 32'hDEADBEEF; #1;
        sb.push_back('{name:"mem12_we", val:32'h1});   obs.push_back(32'(mem_we));
        tick();
        addr = 8'd255; #1;
        sb.push_back('{name:"mem255_we", val:32'h1});  obs.push_back(32'(mem_we));
        tick();
        wr_en = 1'b0; #1;
        sb.push_back('{name:"mem_out_pins", val:32'h2D}); obs.push_back(32'(out_pins));
        sb.push_back('{name:"mem_we_idle", val:32'h0});   obs.push_back(32'(mem_we));
        rd_en = 1'b1; addr = 8'd12; #1;
        sb.push_back('{name:"mem12_sel", val:32'h0});  obs.push_back(32'(sel_port_read));
        sb.push_back('{name:"mem12_rd", val:32'h0});   obs.push_back(rd_data);
        rd_en = 1'b0; addr = 8'd3; #1;
        sb.push_back('{name:"norden_sel", val:32'h0}); obs.push_back(32'(sel_port_read));
        sb.push_back('{name:"norden_rd", val:32'h0});  obs.push_back(rd_data);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
            else $display("pass %s: %h", e.name, o);
        end
    endtask

    task automatic test_input();
        exp_t e; logic [31:0] o;
        wr_en = 1'b1; addr = 8'd11; wr_data = 32'h2;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; #1;
        sb.push_back('{name:"mask_rd", val:32'h2}); obs.push_back(rd_data);
        addr = 8'd9;
        @(negedge clk); #4 in_pins = 2'b10;
        @(posedge clk); #1;
        sb.push_back('{name:"in9_after_e0", val:32'h0}); obs.push_back(rd_data);
        sb.push_back('{name:"irq_after_e0", val:32'h0}); obs.push_back(32'(irq));
        @(posedge clk); #1;
        sb.push_back('{name:"in9_after_e1", val:32'h1}); obs.push_back(rd_data);
        addr = 8'd10; #1;
        sb.push_back('{name:"flags_after_e1", val:32'h0}); obs.push_back(rd_data);
        @(posedge clk); #1;
        sb.push_back('{name:"flags_after_e2", val:32'h2}); obs.push_back(rd_data);
        sb.push_back('{name:"irq_after_e2", val:32'h1});   obs.push_back(32'(irq));
        rd_en = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
            else $display("pass %s: %h", e.name, o);
        end
    endtask

    task automatic test_set_wins();
        exp_t e; logic [31:0] o;
        @(negedge clk); #4 in_pins = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_en = 1'b1; addr = 8'd10; wr_data = 32'h2;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b1; #1;
        sb.push_back('{name:"set_wins_flags", val:32'h2}); obs.push_back(rd_data);
        sb.push_back('{name:"set_wins_irq", val:32'h1});   obs.push_back(32'(irq));
        rd_en = 1'b0; wr_en = 1'b1; wr_data = 32'h2;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; #1;
        sb.push_back('{name:"quiet_clr_flags", val:32'h0}); obs.push_back(rd_data);
        sb.push_back('{name:"quiet_clr_irq", val:32'h0});   obs.push_back(32'(irq));
        rd_en = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
            else $display("pass %s: %h", e.name, o);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [31:0] o;
        wr_en = 1'b1; rd_en = 1'b1; addr = 8'd3; wr_data = 32'h0; #1;
        sb.push_back('{name:"rw_pre_rd", val:32'h1});  obs.push_back(rd_data);
        sb.push_back('{name:"rw_sel", val:32'h1});     obs.push_back(32'(sel_port_read));
        sb.push_back('{name:"rw_mem_we", val:32'h0});  obs.push_back(32'(mem_we));
        tick();
        wr_en = 1'b0; #1;
        sb.push_back('{name:"rw_post_rd", val:32'h0});     obs.push_back(rd_data);
        sb.push_back('{name:"rw_out_pins", val:32'h25});   obs.push_back(32'(out_pins));
        rd_en = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
            else $display("pass %s: %h", e.name, o);
        end
    endtask

    task automatic test_async_reset();
        exp_t e; logic [31:0] o;
        wr_en = 1'b1; wr_data = 32'h1;
        for (int i = 0; i < 8; i++) begin
            addr = 8'(i);
            tick();
        end
        wr_en = 1'b0; in_pins = 2'b11;
        repeat (4) tick();
        rd_en = 1'b1; addr = 8'd10; #1;
        sb.push_back('{name:"pre_rst_flags", val:32'h3});  obs.push_back(rd_data);
        sb.push_back('{name:"pre_rst_out", val:32'hFF});   obs.push_back(32'(out_pins));
        sb.push_back('{name:"pre_rst_irq", val:32'h1});    obs.push_back(32'(irq));
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b1; addr = 8'd0; wr_data = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        sb.push_back('{name:"async_rst_out", val:32'hA5}); obs.push_back(32'(out_pins));
        sb.push_back('{name:"async_rst_irq", val:32'h0});  obs.push_back(32'(irq));
        wr_en = 1'b0; rd_en = 1'b1; addr = 8'd10; #1;
        sb.push_back('{name:"async_rst_flags", val:32'h0}); obs.push_back(rd_data);
        addr = 8'd11; #1;
        sb.push_back('{name:"async_rst_mask", val:32'h0});  obs.push_back(rd_data);
        rd_en = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e.val) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
            else $display("pass %s: %h", e.name, o);
        end
    endtask

    initial begin
        test_reset();
        test_out_store();
        test_mem();
        test_input();
        test_set_wins();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the MIPS32 datapath load/store path and the data memory.
- Decodes the store/load address into one of four targets: registered output port bits, synchronised input port bits, a sticky edge-status register with interrupt mask, or data memory.
- Adds input synchronisation, input change detection, a maskable interrupt request and read-back of output ports.

Parameters:
- ADDR_W, 8, width of the decoded address.
- OUT_PORTS, 8, number of 1-bit output ports, mapped at addresses 0..OUT_PORTS-1.
- IN_PORTS, 2, number of 1-bit input ports, mapped at IN_BASE..IN_BASE+IN_PORTS-1.
- IN_BASE, 8, first input port address. Legal only if IN_BASE >= OUT_PORTS and IN_BASE+IN_PORTS+2 <= 2^ADDR_W.
- SYNC_STAGES, 2, flip-flop synchroniser depth for in_pins (minimum 2).
- OUT_RESET, 0, reset value of out_pins (OUT_PORTS bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  load/store address
- wr_en  in  1  store strobe
- rd_en  in  1  load strobe
- wr_data  in  32  store data
- in_pins  in  IN_PORTS  asynchronous external inputs
- out_pins  out  OUT_PORTS  registered output ports
- mem_we  out  1  data memory write enable
- sel_port_read  out  1  writeback mux select: 1 = rd_data, 0 = memory
- rd_data  out  32  port read data
- irq  out  1  interrupt request

Behaviour:
- Clocking and reset: one clock domain. Asynchronous active-low reset; clk and rst_n are the only clock/reset.
- Reset state:
  - out_pins = OUT_RESET.
  - Synchroniser stages, prev register, status flags and mask = 0.
  - Outputs driven from these registers take their reset values. mem_we = 0, sel_port_read = 0, rd_data = 0 and irq = 0 while strobes are low.
- Address map, decoded combinationally:
  - OUT: addr < OUT_PORTS.
  - IN: IN_BASE <= addr < IN_BASE+IN_PORTS.
  - STAT: addr == IN_BASE+IN_PORTS.
  - MASK: addr == IN_BASE+IN_PORTS+1.
  - MEM: all other addresses, including any gap between OUT_PORTS and IN_BASE.
- mem_we = wr_en and MEM; combinational, zero latency.
- sel_port_read = rd_en and (OUT, IN, STAT or MASK); combinational.
- rd_data, combinational from registered state, zero-extended to 32 bits:
  - OUT: out_pins[addr].
  - IN: sync_last[addr-IN_BASE].
  - STAT: flags.
  - MASK: mask.
  - All other cases: 0.
  - rd_data is 0 whenever sel_port_read = 0.
- Stores, applied at the clock edge where wr_en = 1:
  - OUT: out_pins[addr] <= wr_data[0]; other bits unchanged. New value is visible on out_pins the same edge.
  - IN: ignored; no memory write.
  - STAT: write-1-to-clear. flags[i] cleared where wr_data[i] = 1.
  - MASK: mask <= wr_data[IN_PORTS-1:0].
- Input path:
  - in_pins pass through SYNC_STAGES flops.
  - prev <= sync_last each edge; edge = sync_last XOR prev.
  - flags[i] <= (flags[i] and not clr[i]) or edge[i].
  - If an edge and a clear hit the same bit in the same cycle, set wins.
- Input latency: an in_pins change sampled at edge E0 is:
  - readable via IN after edge E0+SYNC_STAGES-1, i.e. the 2nd edge for the default depth;
  - set in flags one edge later.
- Both rising and falling transitions set the flag.
- A pin held high through reset release sets its flag SYNC_STAGES+1 edges after release. Software clears it at init.
- irq = OR of (flags AND mask), combinational from registers, so glitch-free.
- wr_en and rd_en high in the same cycle: both take effect; read data shows pre-edge state.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously, including any in-flight synchroniser values.

Test Plan:
- Reset with OUT_RESET = 8'hA5 -> out_pins = 8'hA5, irq = 0, mem_we = 0. Load from addr 10 -> rd_data = 0, sel_port_read = 1.
- Store wr_data = 1 to addr 3, then wr_data = 0 to addr 7 -> out_pins = 8'h2D. Load from addr 3 -> rd_data = 1. mem_we stays 0 throughout.
- Store to addr 12, then addr 255 -> mem_we = 1 in the same cycle, out_pins unchanged. Load from addr 12 -> sel_port_read = 0, rd_data = 0.
- Drive in_pins[1] 0->1 just before edge E0 -> load addr 9 returns 0 before E1 and 1 after E1. flags = 2'b10 after E2. With mask = 2'b10 (store 2 to addr 11), irq = 1 after E2.
- Store 2'b10 to addr 10 in the same cycle as a new in_pins[1] edge reaches prev -> flag remains 1 (set wins). Clear again on a quiet cycle -> flags = 0, irq = 0.
- Assert rst_n low mid-store with out_pins = 8'hFF and flags = 2'b11 -> out_pins = OUT_RESET and flags = 0 immediately, without waiting for a clock edge.
